uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, N data bits LSB-first, one stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         rst,
    input  logic         rx_en,
    input  logic         Rx,
    input  logic [9:0]   Load_Value,
    output logic [N-1:0] data,
    output logic         done,
    output logic         busy,
`ifdef UART_RX_PARITY_EN
    output logic         parity_err,
`endif
    output logic         frame_err
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;
`ifdef UART_RX_PARITY_EN
    localparam state_t S_AFTER_DATA = S_PARITY;
`else
    localparam state_t S_AFTER_DATA = S_STOP;
`endif
    state_t       r_state, w_next;
    logic         r_rx_meta, r_rx_s;
    logic [9:0]   r_pre;
    logic [3:0]   r_os;
    logic [2:0]   r_bit;
    logic [N-1:0] r_shift;
`ifdef UART_RX_PARITY_EN
    logic         r_par;
`endif
    logic         w_tick, w_mid, w_end, w_last_bit;

    assign w_tick     = r_pre == Load_Value;
    assign w_mid      = w_tick && r_os == 4'd7;
    assign w_end      = w_tick && r_os == 4'd15;
    assign w_last_bit = r_bit == 3'(N - 1);
    assign busy       = r_state != S_IDLE;

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            r_state <= S_IDLE;
        else if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = (rx_en && !r_rx_s) ? S_START : S_IDLE;
            S_START:  w_next = w_mid ? (r_rx_s ? S_IDLE : S_DATA) : S_START;
            S_DATA:   w_next = (w_end && w_last_bit) ? S_AFTER_DATA : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_PARITY: w_next = w_end ? S_STOP : S_PARITY;
`endif
            S_STOP:   w_next = w_end ? S_IDLE : S_STOP;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_pre     <= '0;
            r_os      <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            data      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_pre     <= '0;
            r_os      <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            data      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            r_rx_meta <= Rx;
            r_rx_s    <= r_rx_meta;
            done      <= 1'b0;
            if (r_state == S_IDLE) begin
                r_pre <= '0;
                r_os  <= '0;
                r_bit <= '0;
            end else begin
                r_pre <= w_tick ? 10'd0 : r_pre + 10'd1;
                // the start-bit check realigns the oversample phase to mid-bit
                if (w_tick)
                    r_os <= (r_state == S_START && r_os == 4'd7) ? 4'd0 : r_os + 4'd1;
                if (r_state == S_DATA && w_end) begin
                    r_shift <= {r_rx_s, r_shift[N-1:1]};
                    r_bit   <= r_bit + 3'd1;
                end
`ifdef UART_RX_PARITY_EN
                if (r_state == S_PARITY && w_end)
                    r_par <= r_rx_s;
`endif
                if (r_state == S_STOP && w_end) begin
                    data      <= r_shift;
                    frame_err <= ~r_rx_s;
                    done      <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err <= ^{r_shift, r_par};
`endif
                end
            end
        end
    end
endmodule
